seq_ripple_adder: RTL and testbench
===================================

SEQ_RIPPLE_ADDER -- requirements
Module: seq_ripple_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/sum width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: bits added per cycle; WIDTH % DIGIT == 0 and DIGIT >= 1 are required, checked at elaboration.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port valid_i, input, 1: operands valid.
REQ-006 SHALL have port ready_o, output, 1: block can accept operands.
REQ-007 SHALL have ports a_i and b_i, input, WIDTH each: unsigned/two's-complement operands.
REQ-008 SHALL have port ci_i, input, 1: carry-in.
REQ-009 SHALL have port valid_o, output, 1: result valid.
REQ-010 SHALL have port ready_i, input, 1: consumer accepts the result.
REQ-011 SHALL have port sum_o, output, WIDTH: a+b+ci modulo 2^WIDTH.
REQ-012 SHALL have port co_o, output, 1: carry out of the MSB.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL drive ready_o = (state == IDLE), combinationally from the state only.
REQ-015 SHALL, in IDLE with valid_i && ready_o at an edge, capture a_i, b_i and ci_i into internal registers, clear the digit counter, and go to RUN.
REQ-016 SHALL, in RUN, each cycle add digit slice [cnt*DIGIT +: DIGIT] of the captured operands plus the carry register, write that sum slice, update the carry register and increment cnt.
REQ-017 SHALL go from RUN to DONE on the edge that processes the last digit (cnt == WIDTH/DIGIT-1), loading co_o from the final carry on that same edge.
REQ-018 SHALL give a latency of exactly WIDTH/DIGIT cycles from the accepting edge to valid_o high; with WIDTH == DIGIT this is 1 cycle.
REQ-019 SHALL hold valid_o = 1 in DONE with sum_o and co_o stable until valid_o && ready_i at an edge, then go to IDLE.
REQ-020 SHALL have ready_o = 0 in DONE, so accept and result handshakes never complete in the same cycle.
REQ-021 SHALL ignore valid_i and input changes in RUN and DONE; captured operands are immutable until the next accept.
REQ-022 SHALL ignore ready_i outside DONE.
REQ-023 SHALL let sum_o show partial results during RUN; sum_o is defined only while valid_o = 1.

Reset
REQ-024 SHALL, on an edge with rst_ni = 0, set state = IDLE, cnt = 0, carry = 0, sum_o = 0, co_o = 0 and valid_o = 0; ready_o is then 1.
REQ-025 SHALL, on reset during RUN or DONE, abort the operation with no valid_o pulse; the first edge after rst_ni returns to 1 may accept new operands.

Configuration
REQ-026 SHALL, with macro SEQ_RIPPLE_ADDER_OVF_EN defined, add output ovf_o (1 bit): signed overflow, i.e. carry into MSB XOR carry out. ovf_o is registered with co_o, reset to 0, and valid under valid_o.
REQ-027 SHALL, without SEQ_RIPPLE_ADDER_OVF_EN, have no ovf_o port and no related logic.

Structure
REQ-028 SHALL place the state enum type (IDLE/RUN/DONE) in shared package seq_adder_pkg.
REQ-029 SHALL place in seq_adder_pkg a function computing the counter width, $clog2 of WIDTH/DIGIT with a minimum of 1.
REQ-030 SHALL build the per-cycle adder as sub-module digit_adder.
  - digit_adder is a DIGIT-bit combinational ripple chain of one-bit full adders.
  - Ports: a, b, ci, sum, co, plus the carry into its MSB for the overflow feature.

Verification
REQ-031 SHALL cover a basic add (WIDTH=16, DIGIT=4): a=0x1234, b=0x1111, ci=0 -> after 4 cycles valid_o=1, sum_o=0x2345, co_o=0.
REQ-032 SHALL cover full carry ripple: a=0xFFFF, b=0x0000, ci=1 -> sum_o=0x0000, co_o=1, latency 4.
REQ-033 SHALL cover backpressure: ready_i held 0 for 5 cycles after valid_o -> sum_o/co_o stable, ready_o=0, new valid_i ignored; ready_i=1 -> IDLE next edge.
REQ-034 SHALL cover reset mid-RUN: rst_ni=0 at cnt=2 -> valid_o=0, sum_o=0, ready_o=1; a new add then completes correctly.
REQ-035 SHALL cover the overflow feature with SEQ_RIPPLE_ADDER_OVF_EN defined: 0x7FFF+0x0001 -> sum_o=0x8000, ovf_o=1, co_o=0; 0xFFFF+0x0001 -> ovf_o=0, co_o=1.
REQ-036 SHALL cover the exhaustive small configuration WIDTH=4, DIGIT=1 and DIGIT=4: all 512 (a,b,ci) combinations match a+b+ci at the documented latency.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// ============================================================================
// Module      : seq_adder_pkg
// Description : Shared types and helpers for the digit-serial ripple adder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package seq_adder_pkg;

    // Controller states of the digit-serial adder, fixed 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the digit counter: enough bits to count WIDTH/DIGIT digits, never zero
    function automatic int cnt_width(input int width, input int digit);
        int n;
        if (digit < 1) begin
            return 1;
        end
        n = width / digit;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_ripple_adder_digit_adder.sv
// ============================================================================
// Module      : digit_adder
// Description : DIGIT-bit combinational ripple chain of one-bit full adders.
//               With SEQ_RIPPLE_ADDER_OVF_EN defined it also exports the carry
//               into its most significant bit (used for signed overflow).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
    ,
    output logic             ci_msb
`endif
);

    // w_c[i] is the carry into bit i; w_c[DIGIT] is the carry out of the digit
    logic [DIGIT:0] w_c;

    assign w_c[0] = ci;

    // One full adder per bit, carries rippling upward
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign co = w_c[DIGIT];

`ifdef SEQ_RIPPLE_ADDER_OVF_EN
    assign ci_msb = w_c[DIGIT-1];
`endif

endmodule

`default_nettype wire

// File: rtl/seq_ripple_adder.sv
// ============================================================================
// Module      : seq_ripple_adder
// Description : Digit-serial adder. Captures two WIDTH-bit operands plus a
//               carry-in, adds DIGIT bits per clock, and presents sum/carry
//               with a valid/ready handshake. Latency is WIDTH/DIGIT cycles.
//               Optional macro SEQ_RIPPLE_ADDER_OVF_EN adds the ovf_o
//               signed-overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_ripple_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             co_o
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int              c_NDIG = WIDTH / DIGIT;
    localparam int              c_CW   = cnt_width(WIDTH, DIGIT);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NDIG - 1);

    // Reject configurations that cannot be split into whole digits
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("seq_ripple_adder: DIGIT must be >= 1 and divide WIDTH");
    end

    state_e             r_state;
    logic [c_CW-1:0]    r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_co;

    logic [DIGIT-1:0]   w_a_dig;
    logic [DIGIT-1:0]   w_b_dig;
    logic [DIGIT-1:0]   w_sum_dig;
    logic               w_co_dig;

    // Current digit of each captured operand
    assign w_a_dig = r_a[r_cnt*DIGIT +: DIGIT];
    assign w_b_dig = r_b[r_cnt*DIGIT +: DIGIT];

`ifdef SEQ_RIPPLE_ADDER_OVF_EN
    logic               w_ci_msb_dig;
    logic               r_ovf;

    digit_adder #(
        .DIGIT  (DIGIT)
    ) u_digit_adder (
        .a      (w_a_dig),
        .b      (w_b_dig),
        .ci     (r_carry),
        .sum    (w_sum_dig),
        .co     (w_co_dig),
        .ci_msb (w_ci_msb_dig)
    );

    // Overflow flag loaded alongside the final carry; only meaningful on the top digit
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ovf <= 1'b0;
        end else if ((r_state == RUN) && (r_cnt == c_LAST)) begin
            r_ovf <= w_ci_msb_dig ^ w_co_dig;
        end
    end

    assign ovf_o = r_ovf;
`else
    digit_adder #(
        .DIGIT  (DIGIT)
    ) u_digit_adder (
        .a      (w_a_dig),
        .b      (w_b_dig),
        .ci     (r_carry),
        .sum    (w_sum_dig),
        .co     (w_co_dig)
    );
`endif

    // Control FSM and datapath: capture in IDLE, one digit per cycle in RUN, hold in DONE
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_co    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_a     <= a_i;
                        r_b     <= b_i;
                        r_carry <= ci_i;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_cnt*DIGIT +: DIGIT] <= w_sum_dig;
                    r_carry                     <= w_co_dig;
                    r_cnt                       <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_co    <= w_co_dig;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decoded purely from the state
    assign ready_o = (r_state == IDLE);
    assign valid_o = (r_state == DONE);
    assign sum_o   = r_sum;
    assign co_o    = r_co;

endmodule

`default_nettype wire

// File: tb/tb_seq_ripple_adder.sv
// ============================================================================
// Module      : tb_seq_ripple_adder
// Description : Self-checking bench for seq_ripple_adder (16/4 main instance,
//               plus 4/1 and 4/4 instances swept exhaustively). Checks against
//               an arithmetic model a+b+ci. Honours SEQ_RIPPLE_ADDER_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_ripple_adder;

    localparam int W   = 16;
    localparam int D   = 4;
    localparam int LAT = W / D;

    int n_vec = 0;
    int n_err = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic         rst_n;
    logic         valid_i;
    logic         ready_i;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] sum_o;
    logic         co_o;

    // Small instances share their inputs
    logic         s_valid;
    logic         s_ready;
    logic [3:0]   s_a;
    logic [3:0]   s_b;
    logic         s_ci;
    logic         s1_ready, s1_valid, s1_co;
    logic [3:0]   s1_sum;
    logic         s4_ready, s4_valid, s4_co;
    logic [3:0]   s4_sum;

`ifdef SEQ_RIPPLE_ADDER_OVF_EN
    logic         ovf_o;
    logic         s1_ovf;
    logic         s4_ovf;
`endif

    seq_ripple_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a),
        .b_i     (b),
        .ci_i    (ci),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sum_o   (sum_o),
        .co_o    (co_o)
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
        ,
        .ovf_o   (ovf_o)
`endif
    );

    seq_ripple_adder #(.WIDTH(4), .DIGIT(1)) u_dut_w4d1 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (s_valid),
        .ready_o (s1_ready),
        .a_i     (s_a),
        .b_i     (s_b),
        .ci_i    (s_ci),
        .valid_o (s1_valid),
        .ready_i (s_ready),
        .sum_o   (s1_sum),
        .co_o    (s1_co)
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
        ,
        .ovf_o   (s1_ovf)
`endif
    );

    seq_ripple_adder #(.WIDTH(4), .DIGIT(4)) u_dut_w4d4 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (s_valid),
        .ready_o (s4_ready),
        .a_i     (s_a),
        .b_i     (s_b),
        .ci_i    (s_ci),
        .valid_o (s4_valid),
        .ready_i (s_ready),
        .sum_o   (s4_sum),
        .co_o    (s4_co)
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
        ,
        .ovf_o   (s4_ovf)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Signed overflow: operands agree in sign but the result does not
    function automatic logic ref_ovf(input logic xs, input logic ys, input logic ss);
        return (xs == ys) && (ss != xs);
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    // Called just after a rising edge with ready_o high; returns just after the accepting edge
    task automatic start_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a       = x;
        b       = y;
        ci      = c;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        a       = W'($urandom);
        b       = W'($urandom);
        ci      = 1'($urandom);
    endtask

    // Counts edges since the accept until valid_o; -1 if the bound expires
    task automatic wait_valid(input bit noise, output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (valid_o) begin
                lat = k;
                break;
            end
            if (noise) ready_i = 1'($urandom);
        end
        ready_i = 1'b0;
    endtask

    task automatic release_result();
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_vec++; if (sum_o !== '0) begin n_err++; $display("FAIL reset_sum: got %h want 0000", sum_o); end
        n_vec++; if (co_o !== 1'b0) begin n_err++; $display("FAIL reset_co: got %b want 0", co_o); end
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
        n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        start_add(16'h1234, 16'h1111, 1'b0);
        wait_valid(1'b0, lat);
        n_vec++; if (lat != LAT) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        n_vec++; if (sum_o !== 16'h2345) begin n_err++; $display("FAIL basic_sum: got %h want 2345", sum_o); end
        n_vec++; if (co_o !== 1'b0) begin n_err++; $display("FAIL basic_co: got %b want 0", co_o); end
        n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL basic_ready_done: got %b want 0", ready_o); end
        release_result();
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop: got %b want 0", valid_o); end
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL basic_ready_idle: got %b want 1", ready_o); end
    endtask

    task automatic test_ripple();
        int lat;
        start_add(16'hFFFF, 16'h0000, 1'b1);
        wait_valid(1'b0, lat);
        n_vec++; if (lat != LAT) begin n_err++; $display("FAIL ripple_latency: got %0d want %0d", lat, LAT); end
        n_vec++; if (sum_o !== 16'h0000) begin n_err++; $display("FAIL ripple_sum: got %h want 0000", sum_o); end
        n_vec++; if (co_o !== 1'b1) begin n_err++; $display("FAIL ripple_co: got %b want 1", co_o); end
        release_result();
    endtask

    task automatic test_backpressure();
        int           lat;
        logic [W-1:0] x, y;
        logic         c;
        logic [W:0]   exp;
        x = W'($urandom); y = W'($urandom); c = 1'($urandom);
        exp = ref_add(x, y, c);
        start_add(x, y, c);
        wait_valid(1'b0, lat);
        n_vec++; if (lat != LAT) begin n_err++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
        for (int k = 0; k < 5; k++) begin
            valid_i = 1'b1;
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
            @(posedge clk); #1;
            n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid_hold: got %b want 1", valid_o); end
            n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %b want 0", ready_o); end
            n_vec++; if (sum_o !== exp[W-1:0]) begin n_err++; $display("FAIL bp_sum_stable: got %h want %h", sum_o, exp[W-1:0]); end
            n_vec++; if (co_o !== exp[W]) begin n_err++; $display("FAIL bp_co_stable: got %b want %b", co_o, exp[W]); end
        end
        valid_i = 1'b0;
        release_result();
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", valid_o); end
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", ready_o); end
    endtask

    task automatic test_reset_mid_run();
        int           lat;
        logic [W-1:0] x, y;
        logic [W:0]   exp;
        start_add(16'hABCD, 16'h5678, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rstrun_valid: got %b want 0", valid_o); end
        n_vec++; if (sum_o !== '0) begin n_err++; $display("FAIL rstrun_sum: got %h want 0000", sum_o); end
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rstrun_ready: got %b want 1", ready_o); end
        n_vec++; if (co_o !== 1'b0) begin n_err++; $display("FAIL rstrun_co: got %b want 0", co_o); end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rstrun_no_pulse: got %b want 0", valid_o); end
        end
        x = W'($urandom); y = W'($urandom);
        exp = ref_add(x, y, 1'b0);
        start_add(x, y, 1'b0);
        wait_valid(1'b0, lat);
        n_vec++; if (lat != LAT) begin n_err++; $display("FAIL rstrun_after_lat: got %0d want %0d", lat, LAT); end
        n_vec++; if ({co_o, sum_o} !== exp) begin n_err++; $display("FAIL rstrun_after_sum: got %h want %h", {co_o, sum_o}, exp); end
        release_result();
    endtask

    task automatic test_random();
        int           lat;
        logic [W-1:0] x, y;
        logic         c;
        logic [W:0]   exp;
        for (int n = 0; n < 40; n++) begin
            x = W'($urandom); y = W'($urandom); c = 1'($urandom);
            if (n == 0) begin x = '1; y = '1; c = 1'b1; end
            if (n == 1) begin x = '0; y = '0; c = 1'b0; end
            exp = ref_add(x, y, c);
            start_add(x, y, c);
            wait_valid(1'b1, lat);
            n_vec++; if (lat != LAT) begin n_err++; $display("FAIL rand_latency: got %0d want %0d", lat, LAT); end
            n_vec++; if ({co_o, sum_o} !== exp) begin n_err++; $display("FAIL rand_result: got %h want %h (a=%h b=%h ci=%b)", {co_o, sum_o}, exp, x, y, c); end
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
            n_vec++; if (ovf_o !== ref_ovf(x[W-1], y[W-1], exp[W-1])) begin n_err++; $display("FAIL rand_ovf: got %b want %b", ovf_o, ref_ovf(x[W-1], y[W-1], exp[W-1])); end
`endif
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            release_result();
        end
    endtask

`ifdef SEQ_RIPPLE_ADDER_OVF_EN
    task automatic test_ovf();
        int lat;
        start_add(16'h7FFF, 16'h0001, 1'b0);
        wait_valid(1'b0, lat);
        n_vec++; if (sum_o !== 16'h8000) begin n_err++; $display("FAIL ovf_pos_sum: got %h want 8000", sum_o); end
        n_vec++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_pos_ovf: got %b want 1", ovf_o); end
        n_vec++; if (co_o !== 1'b0) begin n_err++; $display("FAIL ovf_pos_co: got %b want 0", co_o); end
        release_result();
        start_add(16'hFFFF, 16'h0001, 1'b0);
        wait_valid(1'b0, lat);
        n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL ovf_wrap_ovf: got %b want 0", ovf_o); end
        n_vec++; if (co_o !== 1'b1) begin n_err++; $display("FAIL ovf_wrap_co: got %b want 1", co_o); end
        release_result();
    endtask
`endif

    task automatic test_exhaustive();
        logic [8:0] v;
        logic [4:0] exp;
        int         lat1, lat4;
        logic [4:0] got1, got4;
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
        logic       ov1, ov4, exp_ov;
`endif
        for (int i = 0; i < 512; i++) begin
            v   = 9'(i);
            exp = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]};
            s_a = v[3:0]; s_b = v[7:4]; s_ci = v[8];
            s_valid = 1'b1;
            @(posedge clk); #1;
            s_valid = 1'b0;
            lat1 = -1; lat4 = -1; got1 = '0; got4 = '0;
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
            ov1 = 1'b0; ov4 = 1'b0;
`endif
            for (int k = 1; k <= 6; k++) begin
                @(posedge clk); #1;
                if (s1_valid && lat1 < 0) begin
                    lat1 = k; got1 = {s1_co, s1_sum};
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
                    ov1 = s1_ovf;
`endif
                end
                if (s4_valid && lat4 < 0) begin
                    lat4 = k; got4 = {s4_co, s4_sum};
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
                    ov4 = s4_ovf;
`endif
                end
            end
            s_ready = 1'b1;
            @(posedge clk); #1;
            s_ready = 1'b0;
            n_vec++; if (lat1 != 4) begin n_err++; $display("FAIL exh_d1_latency: got %0d want 4 (vec %0d)", lat1, i); end
            n_vec++; if (got1 !== exp) begin n_err++; $display("FAIL exh_d1_result: got %h want %h (vec %0d)", got1, exp, i); end
            n_vec++; if (lat4 != 1) begin n_err++; $display("FAIL exh_d4_latency: got %0d want 1 (vec %0d)", lat4, i); end
            n_vec++; if (got4 !== exp) begin n_err++; $display("FAIL exh_d4_result: got %h want %h (vec %0d)", got4, exp, i); end
            n_vec++; if ((s1_ready !== 1'b1) || (s4_ready !== 1'b1)) begin n_err++; $display("FAIL exh_ready: got %b%b want 11 (vec %0d)", s1_ready, s4_ready, i); end
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
            exp_ov = ref_ovf(v[3], v[7], exp[3]);
            n_vec++; if ((ov1 !== exp_ov) || (ov4 !== exp_ov)) begin n_err++; $display("FAIL exh_ovf: got %b%b want %b (vec %0d)", ov1, ov4, exp_ov, i); end
`endif
        end
    endtask

    // Hard stop in case a handshake never completes
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        a       = '0;
        b       = '0;
        ci      = 1'b0;
        s_valid = 1'b0;
        s_ready = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_ci    = 1'b0;
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_reset_mid_run();
        test_random();
`ifdef SEQ_RIPPLE_ADDER_OVF_EN
        test_ovf();
`endif
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
